// File: rtl/shift_pkg.sv
// Shared definitions for the serial deserializer: FSM states, bit-order
// and parity-type constants.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/shift_deser_hold.sv
// Valid/ready holding register between the deserializer FSM and the consumer.
// Handshake: a word transfers on any rising edge where data_valid=1 and
// data_ready=1; data_out/parity_err stay stable while data_valid=1.
module shift_deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             complete,
  input  logic [WIDTH-1:0] word,
  input  logic             perr,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun
);

  // Load a finished word when the slot is free (or being freed this edge),
  // otherwise drop it and latch the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= word;
          parity_err <= perr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver. Rebuilds WIDTH-bit words from a strobed
// serial stream (MSB- or LSB-first), optionally checks a trailing parity
// bit and hands finished words to a valid/ready holding register.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             serial_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun,
  output logic             framing_err,
  output logic             busy
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic            ODD   = (PARITY_ODD != 0);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             par_acc;
  logic             order;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             perr;

  // Next shift-register value for a bit in the middle of a frame, and the
  // value seeded when the very first bit arrives with frame_start.
  always_comb begin
    shifted    = '0;
    first_word = '0;
    if (order == MSB_FIRST) shifted = {shift_reg[WIDTH-2:0], serial_in};
    else                    shifted = {serial_in, shift_reg[WIDTH-1:1]};
    if (msb_first == MSB_FIRST) first_word = {{(WIDTH-1){1'b0}}, serial_in};
    else                        first_word = {serial_in, {(WIDTH-1){1'b0}}};
  end

  // Frame completion is decided on the edge sampling the final bit so the
  // holding register loads on that same edge. A frame_start aborts instead.
  always_comb begin
    complete = 1'b0;
    word     = shifted;
    perr     = 1'b0;
    if (enable && !frame_start) begin
      case (state)
        DATA: if (bit_cnt == LAST && PARITY_EN == 0) complete = 1'b1;
        PAR: begin
          complete = 1'b1;
          word     = shift_reg;
          perr     = par_acc ^ serial_in ^ ODD;
        end
        default: ;
      endcase
    end
  end

  // Receive FSM with bit counter, shift register, parity accumulator and
  // registered busy/framing_err outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_acc     <= 1'b0;
      order       <= LSB_FIRST;
      busy        <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      if (frame_start) begin
        framing_err <= (state != IDLE);
        state       <= DATA;
        busy        <= 1'b1;
        order       <= msb_first;
        if (enable) begin
          bit_cnt   <= CNT_W'(1);
          shift_reg <= first_word;
          par_acc   <= serial_in;
        end else begin
          bit_cnt   <= '0;
          shift_reg <= '0;
          par_acc   <= 1'b0;
        end
      end else if (enable) begin
        case (state)
          DATA: begin
            shift_reg <= shifted;
            par_acc   <= par_acc ^ serial_in;
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PAR;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PAR: begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  shift_deser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .reset_n    (reset_n),
    .complete   (complete),
    .word       (word),
    .perr       (perr),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser (WIDTH=8, even parity enabled).
module tb_shift_deser;

  localparam int W   = 8;
  localparam logic ODD = 1'b0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         frame_start = 1'b0;
  logic         msb_first = 1'b0;
  logic         serial_in = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         overrun;
  logic         framing_err;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;
  int fe_count = 0;
  logic [W:0] exp_q[$];

  shift_deser #(.WIDTH(W), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .serial_in   (serial_in),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: compare each word as the consumer accepts it
  always @(negedge clk) begin
    if (reset_n && framing_err) fe_count++;
    if (reset_n && data_valid && data_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_unexpected: got data=%h perr=%b, expected nothing", data_out, parity_err);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({parity_err, data_out} !== e) begin
          tests_failed++;
          $display("FAIL scoreboard_word: got data=%h perr=%b, expected data=%h perr=%b",
                   data_out, parity_err, e[W-1:0], e[W]);
        end
      end
    end
  end

  function automatic logic exp_perr(input logic [W-1:0] w, input logic pbit);
    return (^w) ^ pbit ^ ODD;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // driver: one complete frame (data bits then parity bit), gap idle
  // strobes after each data bit
  task automatic send_frame(input logic [W-1:0] w, input logic msb, input logic pbit,
                            input int gap, input bit push, input bit chk_busy);
    msb_first = msb;
    if (push) exp_q.push_back({exp_perr(w, pbit), w});
    for (int i = 0; i <= W; i++) begin
      frame_start = (i == 0);
      enable      = 1'b1;
      serial_in   = (i < W) ? (msb ? w[W-1-i] : w[i]) : pbit;
      step();
      frame_start = 1'b0;
      enable      = 1'b0;
      if (i < W) begin
        if (chk_busy) begin
          tests_run++;
          if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_frame: bit %0d busy=%b expected 1", i, busy);
          end
        end
        repeat (gap) begin
          step();
          if (chk_busy) begin
            tests_run++;
            if (busy !== 1'b1) begin
              tests_failed++;
              $display("FAIL busy_in_gap: bit %0d busy=%b expected 1", i, busy);
            end
          end
        end
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({data_out, data_valid, parity_err, overrun, framing_err, busy} !== '0) begin
      tests_failed++;
      $display("FAIL %s: data=%h valid=%b perr=%b ovr=%b ferr=%b busy=%b, expected all 0",
               name, data_out, data_valid, parity_err, overrun, framing_err, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset_values");
    reset_n = 1'b1;
    step();
    check_all_zero("after_reset_release");
  endtask

  task automatic test_msb_parity;
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_word: valid=%b data=%h perr=%b, expected 1 a5 0", data_valid, data_out, parity_err);
    end
    step();
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_valid_pulse: valid=%b expected 0 after one cycle", data_valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_busy_fall: busy=%b expected 0", busy);
    end
    step();
  endtask

  task automatic test_lsb_parity;
    data_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'hA5 || parity_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL lsb_word: valid=%b data=%h perr=%b, expected 1 a5 1", data_valid, data_out, parity_err);
    end
    step();
    step();
  endtask

  task automatic test_gaps;
    data_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
      tests_failed++;
      $display("FAIL gaps_word: valid=%b data=%h, expected 1 3c", data_valid, data_out);
    end
    step();
    step();
  endtask

  task automatic test_overrun;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'h11 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_hold: valid=%b data=%h ovr=%b, expected 1 11 1", data_valid, data_out, overrun);
    end
    data_ready = 1'b1;
    step();
    tests_run++;
    if (data_valid !== 1'b0 || overrun !== 1'b1 || data_out !== 8'h11) begin
      tests_failed++;
      $display("FAIL overrun_drain: valid=%b ovr=%b data=%h, expected 0 1 11", data_valid, overrun, data_out);
    end
    step();
  endtask

  task automatic test_resync;
    int fe0;
    logic [3:0] part;
    part = 4'b1010;
    fe0 = fe_count;
    data_ready = 1'b1;
    msb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frame_start = (i == 0);
      enable = 1'b1;
      serial_in = part[3-i];
      step();
    end
    frame_start = 1'b0;
    enable = 1'b0;
    send_frame(8'hF0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'hF0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL resync_word: valid=%b data=%h perr=%b, expected 1 f0 0", data_valid, data_out, parity_err);
    end
    step();
    step();
    tests_run++;
    if (fe_count - fe0 !== 1) begin
      tests_failed++;
      $display("FAIL resync_framing_err: %0d pulse cycles, expected 1", fe_count - fe0);
    end
  endtask

  task automatic test_reset_async;
    data_ready = 1'b1;
    msb_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame_start = (i == 0);
      enable = 1'b1;
      serial_in = 1'b1;
      step();
    end
    frame_start = 1'b0;
    enable = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_frame");
    step();
    reset_n = 1'b1;
    step();
    data_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tests_run++;
    if (data_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre_valid: valid=%b expected 1", data_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_valid");
    step();
    reset_n = 1'b1;
    data_ready = 1'b1;
    step();
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 8'h5A || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_next_word: valid=%b data=%h perr=%b, expected 1 5a 0", data_valid, data_out, parity_err);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w;
    logic         m;
    logic         p;
    data_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      send_frame(w, m, p, 0, 1'b1, 1'b0);
    end
    step();
    step();
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overrun: ovr=%b expected 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_msb_parity();
    test_lsb_parity();
    test_gaps();
    test_overrun();
    test_resync();
    test_reset_async();
    test_back_to_back();
    repeat (3) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver: the far end of the team's parallel-load shift register link. It rebuilds WIDTH-bit words from a strobed serial bit stream, either MSB-first or LSB-first. It can check an optional parity bit, and it hands each finished word to downstream logic through a valid/ready holding register. It sits between the serial link pins and the byte-wide consumer logic.

## Interface
Parameters:
- WIDTH, 8, word length in bits (2..32)
- PARITY_EN, 1, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  bit strobe; serial_in is sampled only on edges where enable=1
- frame_start  in  1  one-cycle frame marker; may coincide with enable
- msb_first  in  1  bit order; captured at frame_start, held for the whole frame
- serial_in  in  1  serial data bit
- data_ready  in  1  consumer accepts data_out while data_valid=1
- data_out  out  WIDTH  received word, stable while data_valid=1
- data_valid  out  1  holding register full
- parity_err  out  1  parity status of the word in data_out
- overrun  out  1  sticky: a finished frame was dropped
- framing_err  out  1  one-cycle pulse: a frame was aborted by frame_start
- busy  out  1  FSM not in IDLE

## Operation
- Reset values: data_out=0, data_valid=0, parity_err=0, overrun=0, framing_err=0, busy=0, FSM=IDLE, bit counter=0.
- Reset deassertion mid-frame: the partial word is discarded.
- FSM states: IDLE, DATA, PAR.
- IDLE → DATA on frame_start=1:
  - bit counter cleared, shift register cleared, parity accumulator cleared, msb_first latched.
  - If enable=1 on the same edge, serial_in is bit 0 of the frame and the counter becomes 1.
- DATA, enable=1: shift in serial_in and increment the counter.
  - MSB-first: shift left, new bit enters bit 0.
  - LSB-first: shift right, new bit enters bit WIDTH-1.
- Last data bit sampled (counter = WIDTH-1 and enable=1):
  - PARITY_EN=1: go to PAR.
  - PARITY_EN=0: complete the frame and go to IDLE.
- PAR, enable=1: sample the parity bit, complete the frame, go to IDLE.
  - parity_err = (XOR of data bits and parity bit) XOR PARITY_ODD.
  - parity_err=0 when PARITY_EN=0.
- Frame completion:
  - data_valid=0, or data_valid=1 with data_ready=1 on the same edge: load data_out and parity_err, set data_valid.
  - Otherwise: drop the word and set overrun.
- Consumption: data_valid=1 and data_ready=1 with no completion on that edge → data_valid clears. data_out holds its last value.
- overrun clears only on reset.
- frame_start while in DATA or PAR:
  - the partial frame is discarded and framing_err pulses for one cycle;
  - the new frame starts exactly as from IDLE, including same-edge bit capture.
- enable=0 stalls the FSM indefinitely and never times out.

## Timing
- All outputs are registered.
- data_valid rises on the clock edge that samples the final bit: the data bit if PARITY_EN=0, the parity bit otherwise. It is visible in the following cycle.
- Minimum frame: WIDTH (+1 with parity) enable cycles. Back-to-back frames need no idle cycle.
- Consumer with data_ready held at 1 sustains full throughput with no overrun.
- framing_err is high for exactly the one cycle after the aborting edge.
- busy rises the cycle after frame_start. It falls the cycle after completion unless a new frame_start coincides.

## Structure
- Shared package shift_pkg:
  - FSM state enum (IDLE, DATA, PAR)
  - bit-order constants (MSB_FIRST=1, LSB_FIRST=0)
  - parity-type constants
- One natural sub-module: shift_deser_hold, the valid/ready holding register carrying data_out, parity_err and overrun logic.
- The FSM, bit counter and shift register stay in the top module.

## Test plan
- MSB-first, WIDTH=8, PARITY_EN=1 even:
  - stimulus: frame_start, serial 1,0,1,0,0,1,0,1, parity 0, data_ready=1
  - response: data_out=8'hA5, parity_err=0, data_valid high for one cycle.
- LSB-first:
  - stimulus: the same serial bits with parity 1
  - response: data_out=8'hA5, parity_err=1.
- Strobe gaps:
  - stimulus: enable=0 for 3 cycles between each bit of 8'h3C
  - response: data_out=8'h3C, busy high throughout the frame.
- Overrun:
  - stimulus: data_ready=0, two complete frames 8'h11 then 8'h22
  - response: data_out stays 8'h11, overrun=1; after data_ready=1, data_valid clears and overrun stays 1.
- Mid-frame resync:
  - stimulus: frame_start after 4 bits, then a full frame of 8'hF0
  - response: framing_err pulses once, data_out=8'hF0.
- Async reset:
  - stimulus: reset_n low mid-frame and while data_valid=1
  - response: all outputs return to reset values immediately; the next full frame 8'h5A is received correctly.
